// File: rtl/dcache_writeline_burst_pkg.sv
// Shared constants, state encoding and word-select helper for the
// posted one-line write-back buffer.
package dcache_writeline_burst_pkg;

    localparam int BURST_BEATS = 4;
    localparam int BEAT_W      = 2;
    localparam int WORD_BITS   = 32;
    localparam int LINE_BITS   = 128;
    localparam int LADDR_BITS  = 28;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_DRAIN = 1'b1
    } wb_state_e;

    function automatic logic [WORD_BITS-1:0] line_word(
        input logic [LINE_BITS-1:0] line,
        input logic [BEAT_W-1:0]    beat
    );
        return line[{beat, 5'd0} +: WORD_BITS];
    endfunction

endpackage

// File: rtl/dcache_writeline_burst_if.sv
// Cache-side writeline/snoop handshake plus the Avalon-MM burst write port.
interface dcache_writeline_burst_if;
    import dcache_writeline_burst_pkg::*;

    logic                  writeline_do;
    logic                  writeline_done;
    logic [31:0]           writeline_address;
    logic [LINE_BITS-1:0]  writeline_line;
    logic [31:0]           snoop_address;
    logic                  snoop_hit;
    logic                  empty;
    logic [29:0]           avm_address;
    logic                  avm_write;
    logic [WORD_BITS-1:0]  avm_writedata;
    logic [3:0]            avm_byteenable;
    logic [2:0]            avm_burstcount;
    logic                  avm_waitrequest;

    // Buffer side: takes the line, drives the memory port.
    modport slave (
        input  writeline_do, writeline_address, writeline_line,
               snoop_address, avm_waitrequest,
        output writeline_done, snoop_hit, empty,
               avm_address, avm_write, avm_writedata,
               avm_byteenable, avm_burstcount
    );

    // Environment side: cache control and Avalon slave.
    modport master (
        output writeline_do, writeline_address, writeline_line,
               snoop_address, avm_waitrequest,
        input  writeline_done, snoop_hit, empty,
               avm_address, avm_write, avm_writedata,
               avm_byteenable, avm_burstcount
    );

endinterface

// File: rtl/dcache_writeline_burst.sv
// Posted one-line write-back buffer: accepts a dirty line in zero cycles when
// free and drains it as a 4-beat 32-bit Avalon burst write.
module dcache_writeline_burst
    import dcache_writeline_burst_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    dcache_writeline_burst_if.slave   bus
);

    wb_state_e               state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [LADDR_BITS-1:0]   addr_q, addr_d;
    logic [LINE_BITS-1:0]    line_q, line_d;

    logic full;
    logic beat_accept;
    logic last_accept;
    logic accept;

    assign full        = (state_q == ST_DRAIN);
    assign beat_accept = full && !bus.avm_waitrequest;
    assign last_accept = beat_accept && (beat_q == BEAT_W'(BURST_BEATS - 1));
    // A new line may replace the draining one in the cycle its last beat goes out.
    assign accept      = bus.writeline_do && (!full || last_accept);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            beat_q  <= '0;
            addr_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        line_d  = line_q;

        case (state_q)
            ST_EMPTY: begin
                beat_d = '0;
            end
            ST_DRAIN: begin
                if (beat_accept) begin
                    beat_d = beat_q + BEAT_W'(1);
                end
                if (last_accept) begin
                    state_d = ST_EMPTY;
                    beat_d  = '0;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                beat_d  = '0;
            end
        endcase

        if (accept) begin
            state_d = ST_DRAIN;
            beat_d  = '0;
            addr_d  = bus.writeline_address[31:4];
            line_d  = bus.writeline_line;
        end
    end

    assign bus.writeline_done = accept;
    assign bus.empty          = !full;
    assign bus.snoop_hit      = full && (bus.snoop_address[31:4] == addr_q);

    assign bus.avm_write      = full;
    assign bus.avm_address    = {addr_q, 2'b00};
    assign bus.avm_writedata  = line_word(line_q, beat_q);
    assign bus.avm_byteenable = 4'hF;
    assign bus.avm_burstcount = 3'(BURST_BEATS);

endmodule

// File: tb/tb_dcache_writeline_burst.sv
// Directed bench for the write-back buffer: handshake timing, burst beats,
// waitrequest stalls, back-to-back lines, snoop and mid-burst reset.
module tb_dcache_writeline_burst;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    dcache_writeline_burst_if bif ();

    dcache_writeline_burst dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle; inputs are changed and outputs sampled
    // mid-cycle, well away from the rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Call in the cycle after acceptance; checks 4 unstalled beats then empty.
    task automatic check_burst(input string tag, input logic [31:0] addr,
                               input logic [127:0] line);
        for (int k = 0; k < 4; k++) begin
            check_eq({tag, "_write"}, bif.avm_write, 1'b1);
            check_eq({tag, "_addr"}, bif.avm_address, addr[31:2] & 30'h3FFF_FFFC);
            check_eq({tag, "_data"}, bif.avm_writedata, line[32*k +: 32]);
            if (k < 3) cyc();
        end
        cyc();
        check_eq({tag, "_empty_after"}, bif.empty, 1'b1);
        check_eq({tag, "_write_after"}, bif.avm_write, 1'b0);
    endtask

    task automatic request(input logic [31:0] addr, input logic [127:0] line);
        bif.writeline_do      = 1'b1;
        bif.writeline_address = addr;
        bif.writeline_line    = line;
    endtask

    logic [127:0] l1, l2, l3, l4;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        l1 = 128'h44443333_22221111_DDDDCCCC_BBBBAAAA;
        l2 = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
        l3 = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
        l4 = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;

        bif.writeline_do      = 1'b0;
        bif.writeline_address = '0;
        bif.writeline_line    = '0;
        bif.snoop_address     = '0;
        bif.avm_waitrequest   = 1'b0;
        rst_n = 1'b0;
        #1;
        cyc();
        cyc();
        check_eq("rst_done",  bif.writeline_done, 1'b0);
        check_eq("rst_write", bif.avm_write, 1'b0);
        check_eq("rst_snoop", bif.snoop_hit, 1'b0);
        check_eq("rst_empty", bif.empty, 1'b1);
        check_eq("rst_addr",  bif.avm_address, 30'h0);
        check_eq("rst_data",  bif.avm_writedata, 32'h0);
        check_eq("rst_be",    bif.avm_byteenable, 4'hF);
        check_eq("rst_bc",    bif.avm_burstcount, 3'd4);
        rst_n = 1'b1;
        cyc();

        // Single line, no stall
        request(32'h0001_2340, l1);
        #1;
        check_eq("t1_done_c0", bif.writeline_done, 1'b1);
        cyc();
        bif.writeline_do = 1'b0;
        #1;
        check_eq("t1_done_c1", bif.writeline_done, 1'b0);
        check_eq("t1_addr", bif.avm_address, 30'h0000_48D0);
        check_burst("t1", 32'h0001_2340, l1);

        // Waitrequest on beat 2 for 3 cycles
        request(32'h0000_0500, l1);
        #1;
        check_eq("t2_done_c0", bif.writeline_done, 1'b1);
        cyc();
        bif.writeline_do = 1'b0;
        #1;
        check_eq("t2_beat0", bif.avm_writedata, 32'hBBBBAAAA);
        cyc();
        check_eq("t2_beat1", bif.avm_writedata, 32'hDDDDCCCC);
        cyc();
        bif.avm_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("t2_hold_data", bif.avm_writedata, 32'h22221111);
            check_eq("t2_hold_write", bif.avm_write, 1'b1);
            check_eq("t2_hold_done", bif.writeline_done, 1'b0);
            cyc();
        end
        bif.avm_waitrequest = 1'b0;
        #1;
        check_eq("t2_beat2", bif.avm_writedata, 32'h22221111);
        cyc();
        check_eq("t2_beat3_c7", bif.avm_writedata, 32'h44443333);
        check_eq("t2_write_c7", bif.avm_write, 1'b1);
        cyc();
        check_eq("t2_empty_c8", bif.empty, 1'b1);
        check_eq("t2_done_c8", bif.writeline_done, 1'b0);

        // Back-to-back lines at 0x100 then 0x200
        request(32'h0000_0100, l2);
        #1;
        check_eq("t3_done_c0", bif.writeline_done, 1'b1);
        cyc();
        request(32'h0000_0200, l3);
        for (int c = 1; c <= 3; c++) begin
            #1;
            check_eq("t3_wait_done", bif.writeline_done, 1'b0);
            check_eq("t3_a_data", bif.avm_writedata, l2[32*(c-1) +: 32]);
            cyc();
        end
        #1;
        check_eq("t3_done_c4", bif.writeline_done, 1'b1);
        check_eq("t3_a_last", bif.avm_writedata, 32'hA3A3A3A3);
        check_eq("t3_a_addr", bif.avm_address, 30'h40);
        cyc();
        bif.writeline_do = 1'b0;
        #1;
        check_burst("t3b", 32'h0000_0200, l3);

        // Request raised at beat 1, last beat stalled one cycle
        request(32'h0000_0300, l2);
        #1;
        check_eq("t4_done_c0", bif.writeline_done, 1'b1);
        cyc();
        bif.writeline_do = 1'b0;
        cyc();
        request(32'h0000_0400, l4);
        #1;
        check_eq("t4_done_beat1", bif.writeline_done, 1'b0);
        cyc();
        check_eq("t4_done_beat2", bif.writeline_done, 1'b0);
        cyc();
        bif.avm_waitrequest = 1'b1;
        #1;
        check_eq("t4_done_stall", bif.writeline_done, 1'b0);
        check_eq("t4_stall_data", bif.avm_writedata, 32'hA3A3A3A3);
        cyc();
        bif.avm_waitrequest = 1'b0;
        #1;
        check_eq("t4_done_last", bif.writeline_done, 1'b1);
        cyc();
        bif.writeline_do = 1'b0;
        #1;
        check_burst("t4b", 32'h0000_0400, l4);

        // Snoop against buffered line at 0x1230
        bif.snoop_address = 32'h0000_123C;
        request(32'h0000_1230, l1);
        #1;
        check_eq("t5_snoop_c0", bif.snoop_hit, 1'b0);
        cyc();
        bif.writeline_do = 1'b0;
        #1;
        check_eq("t5_snoop_hit", bif.snoop_hit, 1'b1);
        bif.snoop_address = 32'h0000_1240;
        #1;
        check_eq("t5_snoop_miss", bif.snoop_hit, 1'b0);
        bif.snoop_address = 32'h0000_123C;
        cyc();
        cyc();
        cyc();
        check_eq("t5_snoop_last", bif.snoop_hit, 1'b1);
        check_eq("t5_last_data", bif.avm_writedata, 32'h44443333);
        cyc();
        check_eq("t5_snoop_after", bif.snoop_hit, 1'b0);

        // Reset during beat 1
        request(32'h0000_0600, l3);
        cyc();
        bif.writeline_do = 1'b0;
        cyc();
        check_eq("t6_beat1", bif.avm_writedata, 32'hB1B1B1B1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_write", bif.avm_write, 1'b0);
        check_eq("t6_rst_empty", bif.empty, 1'b1);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_eq("t6_no_beats", bif.avm_write, 1'b0);
        end
        check_eq("t6_data_clear", bif.avm_writedata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
